// File: rtl/huffman_pkg.sv
// Shared constants, types and codebook for the serial Huffman encoder/decoder pair.
// Codebook: 18 prefix-free codes, 2..8 bits. huff_lookup() returns
// {valid, len, code}, with the code left-aligned in MAX_LEN bits.
package huffman_pkg;

  localparam int unsigned NUM_SYM = 18;
  localparam int unsigned SYM_W   = 5;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;

  typedef enum logic {IDLE, SHIFT} state_e;

  typedef struct packed {
    logic             valid;
    logic [LEN_W-1:0] len;
    logic [MAX_LEN-1:0] code;
  } lut_entry_t;

  // Right-aligned codewords, entry i holds symbol i+1
  localparam logic [MAX_LEN-1:0] CODE_TAB [NUM_SYM] = '{
    8'h00, 8'h01, 8'h02,                              // S1..S3   00 01 10
    8'h06,                                            // S4       110
    8'h38, 8'h39, 8'h3A,                              // S5..S7   111000..111010
    8'h76, 8'h77,                                     // S8, S9   1110110 1110111
    8'h78, 8'h79, 8'h7A, 8'h7B, 8'h7C, 8'h7D, 8'h7E,  // S10..S16 1111000..1111110
    8'hFE, 8'hFF                                      // S17, S18
  };

  localparam logic [LEN_W-1:0] LEN_TAB [NUM_SYM] = '{
    4'd2, 4'd2, 4'd2,
    4'd3,
    4'd6, 4'd6, 4'd6,
    4'd7, 4'd7,
    4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7,
    4'd8, 4'd8
  };

  // Symbol index -> {valid, len, left-aligned code}; out-of-range gives all zero
  function automatic lut_entry_t huff_lookup(input logic [SYM_W-1:0] sym);
    lut_entry_t       e;
    logic [SYM_W-1:0] idx;
    e   = '0;
    idx = sym - SYM_W'(1);
    if (sym >= SYM_W'(1) && sym <= SYM_W'(NUM_SYM)) begin
      e.valid = 1'b1;
      e.len   = LEN_TAB[idx];
      e.code  = CODE_TAB[idx] << (LEN_W'(MAX_LEN) - LEN_TAB[idx]);
    end
    return e;
  endfunction

endpackage

// File: rtl/huffman_code_lut.sv
// Combinational codebook lookup.
// Ports: sym (symbol index) -> entry_c {valid, len, left-aligned code}.
module huffman_code_lut
  import huffman_pkg::*;
(
  input  logic [SYM_W-1:0] sym,
  output lut_entry_t       entry_c
);

  always_comb entry_c = huff_lookup(sym);

endmodule

// File: rtl/huffman_encoder_serial.sv
// Serial Huffman encoder: one symbol per valid/ready handshake, codeword
// shifted out MSB-first one bit per clock, gap-free back-to-back.
// Ports: clk, rst (sync, active-high); sym_in/sym_valid/sym_ready symbol
// input handshake; out/out_valid serial bit stream; busy while shifting;
// err one-cycle pulse when an invalid symbol is accepted and dropped.
module huffman_encoder_serial #(
  parameter int unsigned SYM_W   = huffman_pkg::SYM_W,
  parameter int unsigned MAX_LEN = huffman_pkg::MAX_LEN,
  parameter int unsigned LEN_W   = huffman_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             err
);
  import huffman_pkg::*;

  state_e             state;
  logic [MAX_LEN-1:0] shreg;   // bits still to send after the one on out
  logic [LEN_W-1:0]   cnt;     // bits left including the one on out
  lut_entry_t         entry_c;
  logic [MAX_LEN-1:0] load_code_c;
  logic               take_c;
  logic               last_c;

  huffman_code_lut u_lut (
    .sym     (sym_in),
    .entry_c (entry_c)
  );

  assign load_code_c = MAX_LEN'(entry_c.code);
  assign take_c      = sym_valid & sym_ready;
  assign last_c      = (state == SHIFT) && (cnt == LEN_W'(1));

  // FSM, shift register, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      sym_ready <= 1'b1;
    end else begin
      err <= 1'b0;
      if (state == SHIFT && !last_c) begin
        // Mid-codeword: present next bit; open the input slot for the last bit
        out       <= shreg[MAX_LEN-1];
        shreg     <= {shreg[MAX_LEN-2:0], 1'b0};
        cnt       <= cnt - LEN_W'(1);
        out_valid <= 1'b1;
        busy      <= 1'b1;
        sym_ready <= (cnt == LEN_W'(2));
      end else if (take_c && entry_c.valid) begin
        // Idle or last bit: load a new codeword, first bit goes out next cycle
        state     <= SHIFT;
        out       <= load_code_c[MAX_LEN-1];
        shreg     <= {load_code_c[MAX_LEN-2:0], 1'b0};
        cnt       <= LEN_W'(entry_c.len);
        out_valid <= 1'b1;
        busy      <= 1'b1;
        sym_ready <= (LEN_W'(entry_c.len) == LEN_W'(1));
      end else begin
        // Nothing (or an invalid symbol) to load: drop to idle
        err       <= take_c;
        state     <= IDLE;
        out       <= 1'b0;
        shreg     <= '0;
        cnt       <= '0;
        out_valid <= 1'b0;
        busy      <= 1'b0;
        sym_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_huffman_encoder_serial.sv
// Scoreboard bench for huffman_encoder_serial: the driver pushes the expected
// bit stream at each handshake; a monitor pops and compares every cycle.
module tb_huffman_encoder_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       err;

  huffman_encoder_serial dut (
    .clk       (clk),
    .rst       (rst),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic last;
  } exp_bit_t;

  exp_bit_t    exp_q[$];
  logic        rx_bits[$];
  logic        err_exp  = 1'b0;
  logic        mon_en   = 1'b0;
  logic        capture  = 1'b0;
  int          n_pass   = 0;
  int          n_total  = 0;
  int          cyc      = 0;
  int          last_acc = 0;
  int          last_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_bit(input string name, input logic act, input logic req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b, expected %b at t=%0t", name, act, req, $time);
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
  endtask

  // Codebook as written in the specification; len 0 marks an invalid symbol
  function automatic void model_code(input int s, output int unsigned code,
                                     output int unsigned len);
    code = 0;
    len  = 0;
    if (s >= 10 && s <= 16) begin
      code = 'b1111000 + s - 10;
      len  = 7;
    end else begin
      case (s)
        1:  begin code = 'b00;       len = 2; end
        2:  begin code = 'b01;       len = 2; end
        3:  begin code = 'b10;       len = 2; end
        4:  begin code = 'b110;      len = 3; end
        5:  begin code = 'b111000;   len = 6; end
        6:  begin code = 'b111001;   len = 6; end
        7:  begin code = 'b111010;   len = 6; end
        8:  begin code = 'b1110110;  len = 7; end
        9:  begin code = 'b1110111;  len = 7; end
        17: begin code = 'b11111110; len = 8; end
        18: begin code = 'b11111111; len = 8; end
        default: ;
      endcase
    end
  endfunction

  // Monitor: queue non-empty means a code bit must be on out this cycle
  always begin
    exp_bit_t e;
    logic     busy_exp;
    @(posedge clk);
    #2;
    if (mon_en) begin
      busy_exp = (exp_q.size() != 0);
      check_bit("out_valid", out_valid, busy_exp);
      check_bit("busy", busy, busy_exp);
      check_bit("err", err, err_exp);
      err_exp = 1'b0;
      if (busy_exp) begin
        e = exp_q.pop_front();
        check_bit("out_bit", out, e.b);
        check_bit("sym_ready_shift", sym_ready, e.last);
        if (capture) rx_bits.push_back(out);
      end else begin
        check_bit("out_idle", out, 1'b0);
        check_bit("sym_ready_idle", sym_ready, 1'b1);
      end
    end
  end

  // Offer a symbol (caller at posedge+1); returns at posedge+1 with sym_valid still high
  task automatic issue(input int s);
    bit          held;
    int          waited;
    int unsigned code, len;
    held      = (sym_valid === 1'b1);
    waited    = 0;
    sym_in    = 5'(s);
    sym_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (sym_ready === 1'b1) break;
      waited++;
      if (waited > 20) begin
        check_int("ready_timeout", waited, 0);
        break;
      end
    end
    if (held) check_int("handshake_gap", cyc - last_acc, last_gap);
    last_acc = cyc;
    model_code(s, code, len);
    if (len == 0) begin
      err_exp  = 1'b1;
      last_gap = 1;
    end else begin
      for (int i = int'(len) - 1; i >= 0; i--)
        exp_q.push_back('{b: code[i], last: (i == 0)});
      last_gap = int'(len);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sym_valid = 1'b0;
    sym_in    = 5'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset from posedge+1 of the current cycle; pending bits are discarded
  task automatic do_reset();
    rst       = 1'b1;
    sym_valid = 1'b0;
    @(negedge clk);
    exp_q.delete();
    err_exp = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int          dec_q[$];
    int unsigned v, l, c, cl;
    rst       = 1'b1;
    sym_valid = 1'b0;
    sym_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Single short symbol
    issue(1);
    idle(4);

    // S4, gap, S18
    issue(4);
    idle(5);
    issue(18);
    idle(10);

    // Back-to-back burst with valid held
    issue(5);
    issue(8);
    issue(17);
    idle(10);

    // Invalid symbols in IDLE, then a good one
    issue(0);
    idle(2);
    issue(19);
    idle(2);
    issue(2);
    idle(4);

    // Reset during bit 3 of S9, then S3
    issue(9);
    sym_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    do_reset();
    idle(2);
    issue(3);
    idle(5);

    // Invalid symbol offered on a last-bit cycle
    issue(4);
    issue(25);
    issue(6);
    idle(8);

    // Loopback: S1..S18 back-to-back, decode the captured stream
    capture = 1'b1;
    for (int s = 1; s <= 18; s++) issue(s);
    idle(12);
    capture = 1'b0;
    v = 0;
    l = 0;
    foreach (rx_bits[i]) begin
      v = (v << 1) | 32'(rx_bits[i]);
      l++;
      for (int s = 1; s <= 18; s++) begin
        model_code(s, c, cl);
        if (cl == l && c == v) begin
          dec_q.push_back(s);
          v = 0;
          l = 0;
          break;
        end
      end
    end
    check_int("loop_count", dec_q.size(), 18);
    for (int i = 0; i < 18; i++)
      if (i < dec_q.size()) check_int("loop_sym", dec_q[i], i + 1);

    // Randomized traffic with gaps, invalid symbols and occasional resets
    for (int n = 0; n < 400; n++) begin
      int s;
      if ($urandom_range(0, 7) == 0) s = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(19, 31));
      else s = int'($urandom_range(1, 18));
      issue(s);
      if ($urandom_range(0, 59) == 0) do_reset();
      else if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 5)));
    end
    idle(12);
    check_int("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
